// File: rtl/arb_rr_pry.sv
// Round-robin arbiter built on priority-to-thermometer masking.
// pry2thr turns a request vector into a thermometer that starts at the winning
// position. The top level runs one lookup on masked requests and one on raw
// requests, then registers the chosen one-hot grant behind a valid/ready stage.

module pry2thr #(
    parameter int    WIDTH          = 8,
    parameter int    SPLIT          = 2,
    parameter string DIRECTION      = "LSB",
    parameter int    IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] thr
);

    // A radix below 2 would never widen the prefix window, so clamp it.
    localparam int RADIX = (SPLIT < 2) ? 2 : SPLIT;

    function automatic int tree_levels(input int w, input int r);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < w) begin
            span = span * r;
            lvl  = lvl + 1;
        end
        return lvl;
    endfunction

    function automatic int tree_width(input int w, input int r);
        int span;
        span = 1;
        while (span < w) span = span * r;
        return span;
    endfunction

    localparam int LEVELS = tree_levels(WIDTH, RADIX);
    localparam int PW     = tree_width(WIDTH, RADIX);

    // The core always searches low->high; MSB mode mirrors the vector in and out.
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] res;

    if (DIRECTION == "MSB") begin : g_mirror
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign src[i] = pry[WIDTH-1-i];
            assign thr[i] = res[WIDTH-1-i];
        end
    end else begin : g_direct
        assign src = pry;
        assign thr = res;
    end

    if (IMPLEMENTATION == 0) begin : g_tree
        // Radix-RADIX prefix OR; the vector is zero-padded to a power of RADIX
        // at the top, so padded positions never feed a real output bit.
        always_comb begin
            logic [PW-1:0] acc;
            logic [PW-1:0] prev;
            int            span;
            // NOTE: every combinational variable gets a value before any branch
            // or loop reads it, otherwise synthesis infers a latch.
            acc            = '0;
            acc[WIDTH-1:0] = src;
            prev           = '0;
            span           = 1;
            for (int lvl = 0; lvl < LEVELS; lvl++) begin
                prev = acc;
                for (int i = 0; i < PW; i++) begin
                    for (int k = 1; k < RADIX; k++) begin
                        if (i >= k * span) acc[i] = acc[i] | prev[i - k * span];
                    end
                end
                span = span * RADIX;
            end
            res = acc[WIDTH-1:0];
        end
    end else begin : g_ripple
        // Linear ripple prefix OR: smallest form, longest path.
        always_comb begin
            logic run;
            res = '0;
            run = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                run    = run | src[i];
                res[i] = run;
            end
        end
    end

endmodule

module arb_rr_pry #(
    parameter  int    WIDTH          = 8,
    parameter  int    SPLIT          = 2,
    parameter  string DIRECTION      = "LSB",
    parameter  int    IMPLEMENTATION = 0,
    localparam int    IW             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             vld,
    input  logic             rdy
);

    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] req_m;
    logic [WIDTH-1:0] thr_m;
    logic [WIDTH-1:0] thr_r;
    logic [WIDTH-1:0] oh_m;
    logic [WIDTH-1:0] oh_r;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] thr_sel;
    logic [WIDTH-1:0] msk_nxt;
    logic [IW-1:0]    idx_nxt;
    logic             any_m;
    logic             any_r;
    logic             load;

    assign req_m = req & msk;

    pry2thr #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_thr_masked (
        .pry (req_m),
        .thr (thr_m)
    );

    pry2thr #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_thr_raw (
        .pry (req),
        .thr (thr_r)
    );

    // The winner is the thermometer's first set bit: the one whose neighbour
    // on the search-start side is clear.
    if (DIRECTION == "MSB") begin : g_oh_msb
        assign oh_m = thr_m & ~(thr_m >> 1);
        assign oh_r = thr_r & ~(thr_r >> 1);
    end else begin : g_oh_lsb
        assign oh_m = thr_m & ~(thr_m << 1);
        assign oh_r = thr_r & ~(thr_r << 1);
    end

    assign any_m   = |req_m;
    assign any_r   = |req;
    assign pick    = any_m ? oh_m  : oh_r;
    assign thr_sel = any_m ? thr_m : thr_r;
    // The thermometer covers the pick and everything past it in search order,
    // so removing the pick leaves exactly the positions still owed a turn.
    assign msk_nxt = thr_sel & ~pick;
    assign load    = !vld || rdy;

    // Binary-encode the one-hot pick.
    always_comb begin
        idx_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick[i]) idx_nxt = idx_nxt | IW'(i);
        end
    end

    // Output stage and rotation mask: load a new grant whenever the slot is empty or accepted.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            vld <= 1'b0;
            gnt <= '0;
            idx <= '0;
            msk <= '1;
        end else if (load) begin
            if (any_r) begin
                vld <= 1'b1;
                gnt <= pick;
                idx <= idx_nxt;
                msk <= msk_nxt;
            end else begin
                vld <= 1'b0;
                gnt <= '0;
                idx <= '0;
            end
        end
    end

endmodule
